// File: rtl/jk_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_pkg
// Description : Shared types for the JK flip-flop bank controller.
//               Holds the 3-bit opcode enum, the FSM state enum, and a helper
//               that identifies the multi-step opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_bank_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_CLEAR    = 3'd1,
    OP_SET      = 3'd2,
    OP_LOAD     = 3'd3,
    OP_TOGGLE   = 3'd4,
    OP_COUNT_UP = 3'd5,
    OP_COUNT_DN = 3'd6,
    OP_ROTATE   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Multi-step opcodes take their RUN length from the step count; all others
  // occupy a single RUN cycle.
  function automatic logic is_multi(input op_e op);
    return (op == OP_COUNT_UP) || (op == OP_COUNT_DN) || (op == OP_ROTATE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
// Module      : jk_cell
// Description : Single JK flip-flop with asynchronous active-low clear.
//               j=k=0 holds, j=1/k=0 sets, j=0/k=1 clears, j=k=1 toggles.
// Ports       : j, k  - JK drive inputs
//               clk   - clock, rising edge
//               clrn  - asynchronous active-low clear (q -> 0)
//               q     - flip-flop state
// Revision    : 1.0 - initial release
// ============================================================================
module jk_cell (
  input  logic j,
  input  logic k,
  input  logic clk,
  input  logic clrn,
  output logic q
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= 1'b0;
    end else begin
      q <= (j & ~q) | (~k & q);
    end
  end

endmodule
`default_nettype wire

// File: rtl/jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_ctrl
// Description : Command-driven controller for a bank of W JK flip-flops.
//               Accepts one command at a time, decodes it into J/K drive for
//               the bank, and repeats counting/rotating ops for a programmable
//               number of steps.
// Ports       : clk, clrn            - clock / async active-low reset
//               cmd_valid, cmd_ready - command handshake
//               cmd_op [2:0]         - opcode (jk_bank_pkg::op_e)
//               cmd_data [W-1:0]     - load value or toggle mask
//               cmd_steps [SW-1:0]   - repeat count for ops 5-7
//               busy                 - high in RUN and DONE
//               done                 - one-cycle completion pulse
//               j, k [W-1:0]         - J/K drive applied to the bank
//               q [W-1:0]            - bank state
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_ctrl
  import jk_bank_pkg::*;
#(
  parameter int W  = 4,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [W-1:0]  cmd_data,
  input  logic [SW-1:0] cmd_steps,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  j,
  output logic [W-1:0]  k,
  output logic [W-1:0]  q
);

  state_e        r_state;
  state_e        w_state_nxt;
  op_e           r_op;
  logic [W-1:0]  r_data;
  logic [SW-1:0] r_cnt;
  logic [SW-1:0] w_cnt_nxt;
  logic          r_alive;
  logic          w_accept;
  op_e           w_cmd_op;
  logic [W-1:0]  w_up_mask;
  logic [W-1:0]  w_dn_mask;
  logic [W-1:0]  w_rotl;

  // r_alive keeps cmd_ready low until the first edge after reset release,
  // even though the state is already IDLE during reset.
  assign cmd_ready = r_alive && (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done      = (r_state == ST_DONE);
  assign w_cmd_op  = op_e'(cmd_op);

  // --------------------------------------------------------------------------
  // State register and command capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_op   <= OP_NOP;
      r_data <= '0;
    end else if (w_accept) begin
      r_op   <= w_cmd_op;
      r_data <= cmd_data;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. r_cnt holds the number of RUN cycles still to execute,
  // including the current one; the FSM leaves RUN when it reaches 1.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_multi(w_cmd_op)) begin
            w_cnt_nxt   = cmd_steps;
            // A zero step count skips RUN entirely so q is untouched.
            w_state_nxt = (cmd_steps == '0) ? ST_DONE : ST_RUN;
          end else begin
            w_cnt_nxt   = SW'(1);
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - SW'(1);
        if (r_cnt == SW'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counter masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
  // --------------------------------------------------------------------------
  always_comb begin : p_count_masks
    logic v_carry;
    logic v_borrow;
    v_carry   = 1'b1;
    v_borrow  = 1'b1;
    w_up_mask = '0;
    w_dn_mask = '0;
    for (int i = 0; i < W; i++) begin
      w_up_mask[i] = v_carry;
      w_dn_mask[i] = v_borrow;
      v_carry      = v_carry & q[i];
      v_borrow     = v_borrow & ~q[i];
    end
  end

  assign w_rotl = {q[W-2:0], q[W-1]};

  // --------------------------------------------------------------------------
  // J/K decode; the bank only sees drive while in RUN, so it holds otherwise.
  // --------------------------------------------------------------------------
  always_comb begin
    j = '0;
    k = '0;
    if (r_state == ST_RUN) begin
      case (r_op)
        OP_NOP:      begin j = '0;        k = '0;        end
        OP_CLEAR:    begin j = '0;        k = '1;        end
        OP_SET:      begin j = '1;        k = '0;        end
        OP_LOAD:     begin j = r_data;    k = ~r_data;   end
        OP_TOGGLE:   begin j = r_data;    k = r_data;    end
        OP_COUNT_UP: begin j = w_up_mask; k = w_up_mask; end
        OP_COUNT_DN: begin j = w_dn_mask; k = w_dn_mask; end
        OP_ROTATE:   begin j = w_rotl;    k = ~w_rotl;   end
        default:     begin j = '0;        k = '0;        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Flip-flop bank
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < W; gi++) begin : g_cell
    jk_cell u_cell (
      .j    (j[gi]),
      .k    (k[gi]),
      .clk  (clk),
      .clrn (clrn),
      .q    (q[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_ctrl
// Description : Directed self-checking bench for jk_bank_ctrl (W=4, SW=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_ctrl;

  logic       clk;
  logic       clrn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] cmd_steps;
  logic       busy;
  logic       done;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q;

  int errors = 0;
  int checks = 0;

  jk_bank_ctrl #(.W(4), .SW(4)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_steps (cmd_steps),
    .busy      (busy),
    .done      (done),
    .j         (j),
    .k         (k),
    .q         (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge (accepted when ready), then drop valid.
  task automatic issue(input logic [2:0] op, input logic [3:0] data, input logic [3:0] steps);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_steps = steps;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn      = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 4'd0;
    cmd_steps = 4'd0;

    // ---------------- reset ----------------
    #2 clrn = 1'b0;
    #1;
    chk("rst_q",     q,         4'b0000);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_done",  done,      1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_j",     j,         4'b0000);
    chk("rst_k",     k,         4'b0000);
    @(posedge clk);
    @(posedge clk);
    #2 clrn = 1'b1;
    tick();
    chk("post_rst_ready", cmd_ready, 1'b1);
    chk("post_rst_busy",  busy,      1'b0);

    // ---------------- LOAD 1010 ----------------
    issue(3'd3, 4'b1010, 4'd0);
    chk("load_run_busy",  busy,      1'b1);
    chk("load_run_ready", cmd_ready, 1'b0);
    chk("load_run_j",     j,         4'b1010);
    chk("load_run_k",     k,         4'b0101);
    chk("load_run_q",     q,         4'b0000);
    tick();
    chk("load_q",         q,         4'b1010);
    chk("load_done",      done,      1'b1);
    chk("load_done_j",    j,         4'b0000);
    tick();
    chk("load_done_end",  done,      1'b0);
    chk("load_ready",     cmd_ready, 1'b1);
    chk("load_idle_busy", busy,      1'b0);

    // ---------------- LOAD 1110, then COUNT_UP x3 with wrap ----------------
    issue(3'd3, 4'b1110, 4'd0);
    tick();
    tick();
    chk("setup_1110", q, 4'b1110);
    issue(3'd5, 4'd0, 4'd3);
    chk("up_b1",   busy, 1'b1);
    chk("up_j0",   j,    4'b0001);
    chk("up_k0",   k,    4'b0001);
    tick();
    chk("up_q1",   q,    4'b1111);
    chk("up_b2",   busy, 1'b1);
    chk("up_d1",   done, 1'b0);
    chk("up_j1",   j,    4'b1111);
    tick();
    chk("up_q2",   q,    4'b0000);
    chk("up_b3",   busy, 1'b1);
    chk("up_d2",   done, 1'b0);
    tick();
    chk("up_q3",   q,    4'b0001);
    chk("up_b4",   busy, 1'b1);
    chk("up_done", done, 1'b1);
    tick();
    chk("up_b5",   busy, 1'b0);
    chk("up_d5",   done, 1'b0);
    chk("up_rdy",  cmd_ready, 1'b1);

    // ---------------- COUNT_DN x2 with wrap, then TOGGLE ----------------
    issue(3'd6, 4'd0, 4'd2);
    chk("dn_j0",   j,    4'b0001);
    tick();
    chk("dn_q1",   q,    4'b0000);
    chk("dn_d1",   done, 1'b0);
    chk("dn_j1",   j,    4'b1111);
    tick();
    chk("dn_q2",   q,    4'b1111);
    chk("dn_done", done, 1'b1);
    tick();
    issue(3'd4, 4'b0110, 4'd9);
    chk("tog_j",   j,    4'b0110);
    chk("tog_k",   k,    4'b0110);
    tick();
    chk("tog_q",   q,    4'b1001);
    chk("tog_done", done, 1'b1);
    tick();

    // ---------------- ROTATE steps=0: RUN skipped ----------------
    issue(3'd7, 4'd0, 4'd0);
    chk("rot0_done", done, 1'b1);
    chk("rot0_busy", busy, 1'b1);
    chk("rot0_j",    j,    4'b0000);
    chk("rot0_k",    k,    4'b0000);
    chk("rot0_q",    q,    4'b1001);
    tick();
    chk("rot0_idle_done", done,      1'b0);
    chk("rot0_idle_q",    q,         4'b1001);
    chk("rot0_ready",     cmd_ready, 1'b1);

    // ---------------- ROTATE steps=1: MSB moves to LSB ----------------
    issue(3'd7, 4'd0, 4'd1);
    chk("rot1_j", j, 4'b0011);
    chk("rot1_k", k, 4'b1100);
    tick();
    chk("rot1_q",    q,    4'b0011);
    chk("rot1_done", done, 1'b1);
    tick();

    // ---------------- CLEAR, then COUNT_UP 15 aborted by reset ----------------
    issue(3'd1, 4'd0, 4'd0);
    chk("clr_j", j, 4'b0000);
    chk("clr_k", k, 4'b1111);
    tick();
    chk("clr_q", q, 4'b0000);
    tick();
    issue(3'd5, 4'd0, 4'd15);
    repeat (5) tick();
    chk("abort_pre_q",    q,    4'b0101);
    chk("abort_pre_busy", busy, 1'b1);
    #2 clrn = 1'b0;
    #1;
    chk("abort_q",     q,         4'b0000);
    chk("abort_busy",  busy,      1'b0);
    chk("abort_done",  done,      1'b0);
    chk("abort_ready", cmd_ready, 1'b0);
    chk("abort_j",     j,         4'b0000);
    @(posedge clk);
    #2 clrn = 1'b1;
    tick();
    chk("abort_rel_ready", cmd_ready, 1'b1);
    chk("abort_rel_done",  done,      1'b0);
    tick();
    chk("abort_rel_done2", done, 1'b0);
    chk("abort_rel_q",     q,    4'b0000);

    issue(3'd1, 4'd0, 4'd0);
    tick();
    chk("clr2_q",    q,    4'b0000);
    chk("clr2_done", done, 1'b1);
    tick();

    // ---------------- held cmd_valid during busy COUNT_UP ----------------
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    cmd_data  = 4'd0;
    cmd_steps = 4'd3;
    tick();
    cmd_op    = 3'd3;
    cmd_data  = 4'b1100;
    chk("hold_rdy0", cmd_ready, 1'b0);
    tick();
    chk("hold_q1",   q,         4'b0001);
    chk("hold_rdy1", cmd_ready, 1'b0);
    tick();
    chk("hold_q2",   q,         4'b0010);
    tick();
    chk("hold_q3",   q,         4'b0011);
    chk("hold_done", done,      1'b1);
    chk("hold_rdy3", cmd_ready, 1'b0);
    tick();
    chk("hold_idle_rdy", cmd_ready, 1'b1);
    chk("hold_idle_q",   q,         4'b0011);
    tick();
    cmd_valid = 1'b0;
    chk("hold_acc_busy", busy, 1'b1);
    chk("hold_acc_j",    j,    4'b1100);
    chk("hold_acc_k",    k,    4'b0011);
    tick();
    chk("hold_load_q",    q,    4'b1100);
    chk("hold_load_done", done, 1'b1);
    tick();
    chk("hold_end_ready", cmd_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
